// File: rtl/zle_pkg.sv
// Shared definitions for the zero run-length encoder and its future decoder.
// Holds the FSM state encoding, the token-type flags and the maximum run length helper.
package zle_pkg;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_ZEROS = 2'd1,
        S_PEND  = 2'd2
    } state_t;

    localparam logic TOK_LIT = 1'b0;
    localparam logic TOK_RUN = 1'b1;

    function automatic int unsigned maxrun(input int unsigned cntw);
        return 32'd1 << cntw;
    endfunction

endpackage

// File: rtl/zle_enc_if.sv
// Producer/consumer stream bundle of the zero run-length encoder (valid/busy handshake).
// The slave modport is the encoder's view; master is the producer/consumer side.
interface zle_enc_if #(parameter int W = 8) ();
    logic         i_v;
    logic         i_b;
    logic [W-1:0] i_d;
    logic         i_eos;
    logic         o_v;
    logic         o_b;
    logic [W-1:0] o_d;
    logic         o_z;
    logic         o_eos;

    modport slave  (input  i_v, i_d, i_eos, o_b,
                    output i_b, o_v, o_d, o_z, o_eos);
    modport master (output i_v, i_d, i_eos, o_b,
                    input  i_b, o_v, o_d, o_z, o_eos);
endinterface

// File: rtl/zle_tok_slot.sv
// Single registered output token slot with valid/busy handshake.
// The slot is free when empty or when its token is being taken this cycle.
module zle_tok_slot #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] ld_d,
    input  logic         ld_z,
    input  logic         ld_eos,
    input  logic         o_b,
    output logic         o_v,
    output logic [W-1:0] o_d,
    output logic         o_z,
    output logic         o_eos,
    output logic         free
);

    logic         o_v_r;
    logic [W-1:0] o_d_r;
    logic         o_z_r;
    logic         o_eos_r;

    assign free  = ~o_v_r | ~o_b;
    assign o_v   = o_v_r;
    assign o_d   = o_d_r;
    assign o_z   = o_z_r;
    assign o_eos = o_eos_r;

    // Slot register: load a new token, drop an accepted one, otherwise hold stable.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_v_r   <= 1'b0;
            o_d_r   <= {W{1'b0}};
            o_z_r   <= 1'b0;
            o_eos_r <= 1'b0;
        end else if (load) begin
            o_v_r   <= 1'b1;
            o_d_r   <= ld_d;
            o_z_r   <= ld_z;
            o_eos_r <= ld_eos;
        end else if (free) begin
            o_v_r   <= 1'b0;
        end else begin
            o_v_r   <= o_v_r;
        end
    end

endmodule

// File: rtl/zle_enc.sv
// Parametrised zero run-length encoder: literals pass through, zero runs collapse
// into run tokens of up to maxrun(CNTW) zeros, with end-of-stream flushing.
module zle_enc
    import zle_pkg::*;
#(
    parameter int W    = 8,
    parameter int CNTW = 4
) (
    input  logic          clock,
    input  logic          reset,
    zle_enc_if.slave      bus,
    output logic [1:0]    state_o
);

    localparam int unsigned MAXRUN = maxrun(CNTW);

    state_t            state_r, state_n;
    logic [CNTW-1:0]   cnt_r, cnt_n;
    logic [W-1:0]      pend_d_r, pend_d_n;
    logic              pend_eos_r, pend_eos_n;
    logic              load_s, ld_z_s, ld_eos_s, free_s, accept_s, word_zero_s, run_full_s;
    logic [W-1:0]      ld_d_s;

    assign bus.i_b     = (state_r == S_PEND) | (bus.o_v & bus.o_b);
    assign accept_s    = bus.i_v & ~bus.i_b;
    assign word_zero_s = (bus.i_d == {W{1'b0}});
    assign run_full_s  = (cnt_r == CNTW'(MAXRUN - 32'd1));
    assign state_o     = state_r;

    // State, run counter and pending-literal registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= S_START;
            cnt_r      <= {CNTW{1'b0}};
            pend_d_r   <= {W{1'b0}};
            pend_eos_r <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            pend_d_r   <= pend_d_n;
            pend_eos_r <= pend_eos_n;
        end
    end

    // Next-state and token-load decisions; run tokens carry length minus one.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        pend_d_n   = pend_d_r;
        pend_eos_n = pend_eos_r;
        load_s     = 1'b0;
        ld_d_s     = {W{1'b0}};
        ld_z_s     = TOK_LIT;
        ld_eos_s   = 1'b0;
        case (state_r)
            S_START: begin
                if (accept_s) begin
                    if (!word_zero_s) begin
                        load_s   = 1'b1;
                        ld_d_s   = bus.i_d;
                        ld_eos_s = bus.i_eos;
                    end else if (bus.i_eos) begin
                        load_s   = 1'b1;
                        ld_z_s   = TOK_RUN;
                        ld_eos_s = 1'b1;
                    end else begin
                        cnt_n    = CNTW'(32'd1);
                        state_n  = S_ZEROS;
                    end
                end else begin
                    state_n = S_START;
                end
            end
            S_ZEROS: begin
                if (accept_s) begin
                    if (!word_zero_s) begin
                        load_s     = 1'b1;
                        ld_z_s     = TOK_RUN;
                        ld_d_s     = W'(cnt_r - CNTW'(32'd1));
                        pend_d_n   = bus.i_d;
                        pend_eos_n = bus.i_eos;
                        cnt_n      = {CNTW{1'b0}};
                        state_n    = S_PEND;
                    end else if (run_full_s || bus.i_eos) begin
                        load_s   = 1'b1;
                        ld_z_s   = TOK_RUN;
                        ld_d_s   = W'(cnt_r);
                        ld_eos_s = bus.i_eos;
                        cnt_n    = {CNTW{1'b0}};
                        state_n  = S_START;
                    end else begin
                        cnt_n = cnt_r + CNTW'(32'd1);
                    end
                end else begin
                    state_n = S_ZEROS;
                end
            end
            S_PEND: begin
                if (free_s) begin
                    load_s   = 1'b1;
                    ld_d_s   = pend_d_r;
                    ld_eos_s = pend_eos_r;
                    state_n  = S_START;
                end else begin
                    state_n = S_PEND;
                end
            end
            default: begin
                state_n = S_START;
                cnt_n   = {CNTW{1'b0}};
            end
        endcase
    end

    zle_tok_slot #(.W(W)) u_slot (
        .clock  (clock),
        .reset  (reset),
        .load   (load_s),
        .ld_d   (ld_d_s),
        .ld_z   (ld_z_s),
        .ld_eos (ld_eos_s),
        .o_b    (bus.o_b),
        .o_v    (bus.o_v),
        .o_d    (bus.o_d),
        .o_z    (bus.o_z),
        .o_eos  (bus.o_eos),
        .free   (free_s)
    );

endmodule

// File: tb/tb_zle_enc.sv
// Self-checking bench for zle_enc: directed cases with literal expectations plus
// randomized traffic checked against a queue-based stream model.
module tb_zle_enc;
    localparam int W      = 8;
    localparam int CNTW   = 4;
    localparam int MAXRUN = 1 << CNTW;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_o;

    zle_enc_if #(.W(W)) bus ();

    zle_enc #(.W(W), .CNTW(CNTW)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus.slave),
        .state_o (state_o)
    );

    always #5 clock = ~clock;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         run_len  = 0;
    int         ib_hi    = 0;
    int         ob_mode  = 0;
    logic [9:0] exp_q[$];
    logic [9:0] seen_q[$];
    logic       hold_v   = 1'b0;
    logic [9:0] hold_tok = 10'h000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
        end
    endtask

    // Stream model: tokens are {z, eos, d}; count zeros and close runs on the rules.
    function automatic void model_word(input logic [7:0] d, input logic eos);
        if (d == 8'h00) begin
            run_len++;
            if (run_len == MAXRUN || eos) begin
                exp_q.push_back({1'b1, eos, 8'(run_len - 1)});
                run_len = 0;
            end
        end else begin
            if (run_len > 0) exp_q.push_back({1'b1, 1'b0, 8'(run_len - 1)});
            run_len = 0;
            exp_q.push_back({1'b0, eos, d});
        end
    endfunction

    // Monitor: samples one time unit before each rising edge.
    initial begin
        logic [9:0] tok;
        forever begin
            @(negedge clock);
            #4;
            if (reset) begin
                if (bus.i_b) ib_hi++;
                if (hold_v)
                    chk("hold_stable", {bus.o_v, bus.o_z, bus.o_eos, bus.o_d}, {1'b1, hold_tok});
                if (bus.o_v && bus.o_b) chk("busy_blocks_input", bus.i_b, 1);
                hold_v   = bus.o_v & bus.o_b;
                hold_tok = {bus.o_z, bus.o_eos, bus.o_d};
                if (bus.i_v && !bus.i_b) model_word(bus.i_d, bus.i_eos);
                if (bus.o_v && !bus.o_b) begin
                    tok = {bus.o_z, bus.o_eos, bus.o_d};
                    seen_q.push_back(tok);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_token: got 0x%0h, expected none", tok);
                    end else begin
                        chk("token", tok, exp_q.pop_front());
                    end
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Consumer busy: 0 = ready, 1 = stalled, otherwise random.
    initial begin
        forever begin
            @(negedge clock);
            case (ob_mode)
                0:       bus.o_b = 1'b0;
                1:       bus.o_b = 1'b1;
                default: bus.o_b = 1'($urandom % 2);
            endcase
        end
    end

    task automatic send(input logic [7:0] d, input logic eos);
        int t    = 0;
        bit done = 1'b0;
        bus.i_v   = 1'b1;
        bus.i_d   = d;
        bus.i_eos = eos;
        while (!done) begin
            #2;
            if (!bus.i_b) done = 1'b1;
            @(negedge clock);
            t++;
            if (!done && t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL send_timeout: got busy for %0d cycles, expected acceptance", t);
                done = 1'b1;
            end
        end
        bus.i_v   = 1'b0;
        bus.i_d   = 8'h00;
        bus.i_eos = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || bus.o_v) && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic expect_seen(input string name, input int n,
                               input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [9:0] want[3];
        want[0] = a;
        want[1] = b;
        want[2] = c;
        chk({name, "_count"}, seen_q.size(), n);
        for (int i = 0; i < n; i++)
            if (i < seen_q.size()) chk(name, seen_q[i], want[i]);
        seen_q.delete();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.i_v   = 1'b0;
        bus.i_d   = 8'h00;
        bus.i_eos = 1'b0;
        bus.o_b   = 1'b0;
        #2;
        chk("reset_outputs", {bus.o_v, bus.o_z, bus.o_eos, bus.o_d, bus.i_b, state_o}, 14'h0000);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        // Two literals at full rate.
        ib_hi = 0;
        send(8'h05, 1'b0);
        chk("lit1_latency", {bus.o_v, bus.o_z, bus.o_d}, {1'b1, 1'b0, 8'h05});
        send(8'h07, 1'b0);
        chk("lit2_latency", {bus.o_v, bus.o_z, bus.o_d}, {1'b1, 1'b0, 8'h07});
        drain();
        expect_seen("literals", 2, 10'h005, 10'h007, 10'h000);
        chk("literals_no_stall", ib_hi, 0);

        // Short run terminated by a nonzero: one bubble.
        ib_hi = 0;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h09, 1'b0);
        chk("run3_token", {bus.o_v, bus.o_z, bus.o_d}, {1'b1, 1'b1, 8'h02});
        chk("run3_pend_state", state_o, 2);
        @(negedge clock);
        chk("run3_literal", {bus.o_v, bus.o_z, bus.o_d}, {1'b1, 1'b0, 8'h09});
        drain();
        expect_seen("run3", 2, 10'h202, 10'h009, 10'h000);
        chk("run3_bubble", ib_hi, 1);

        // Twenty zeros split at the maximum run length.
        ib_hi = 0;
        for (int i = 0; i < 20; i++) send(8'h00, 1'b0);
        send(8'h01, 1'b0);
        drain();
        expect_seen("run20", 3, 10'h20F, 10'h203, 10'h001);
        chk("run20_bubble", ib_hi, 1);

        // End-of-stream flushing variants.
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h00, 1'b1);
        drain();
        expect_seen("eos_run3", 1, 10'h302, 10'h000, 10'h000);
        send(8'h00, 1'b1);
        drain();
        expect_seen("eos_lone_zero", 1, 10'h300, 10'h000, 10'h000);
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h33, 1'b1);
        drain();
        expect_seen("eos_literal", 2, 10'h201, 10'h133, 10'h000);

        // Consumer stalled with a run token valid and a literal pending.
        ob_mode = 1;
        bus.o_b = 1'b1;
        send(8'h00, 1'b0);
        send(8'h00, 1'b0);
        send(8'h44, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk("stall_token", {bus.o_v, bus.o_z, bus.o_d}, {1'b1, 1'b1, 8'h01});
            chk("stall_busy", bus.i_b, 1);
            @(negedge clock);
        end
        ob_mode = 0;
        bus.o_b = 1'b0;
        drain();
        expect_seen("stall", 2, 10'h201, 10'h044, 10'h000);

        // Reset in the middle of a run discards it.
        for (int i = 0; i < 7; i++) send(8'h00, 1'b0);
        chk("pre_reset_state", state_o, 1);
        reset = 1'b0;
        #1;
        chk("mid_reset", {bus.o_v, state_o}, 3'b000);
        exp_q.delete();
        seen_q.delete();
        run_len = 0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        send(8'h04, 1'b0);
        drain();
        expect_seen("after_reset", 1, 10'h004, 10'h000, 10'h000);

        // Randomized traffic with a random consumer.
        ob_mode = 2;
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            logic       e;
            if ($urandom % 4 == 0) @(negedge clock);
            d = ($urandom % 10 < 6) ? 8'h00 : 8'($urandom_range(1, 255));
            e = ($urandom % 20 == 0);
            send(d, e);
        end
        send(8'h5A, 1'b1);
        ob_mode = 0;
        drain();
        chk("random_run_closed", run_len, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zle_enc.md
# zle_enc

Parametrised zero run-length encoder: FSM and datapath in one block, replacing the split fixed-width FSM/datapath pair. It sits between a producer stream and a consumer stream using the team's valid/busy handshake. Nonzero words pass through as literal tokens. Runs of zeros collapse into run tokens of up to 2^CNTW zeros. Unlike the previous generation, it supports end-of-stream flushing, a full-throughput output slot and a generic word width.

## Interface
- W, 8: data word width.
- CNTW, 4: run-count field width; max run length MAXRUN = 2^CNTW; CNTW <= W required.
- clock  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- i_v  in  1  input word valid.
- i_b  out  1  input busy; a word transfers on a rising edge with i_v=1, i_b=0.
- i_d  in  W  input word.
- i_eos  in  1  last word of stream, qualified by i_v.
- o_v  out  1  output token valid (registered).
- o_b  in  1  output busy; a token transfers on an edge with o_v=1, o_b=0.
- o_d  out  W  literal value, or run length minus 1 (zero-extended).
- o_z  out  1  1 = run token, 0 = literal.
- o_eos  out  1  token closes the stream.
- state_o  out  2  current FSM state, for debug/datapath visibility.

## Operation
- Token encoding:
  - Literal: o_z=0, o_d=i_d.
  - Run of n zeros (1..MAXRUN): o_z=1, o_d=n-1.
- Output slot: one register holding o_v, o_d, o_z and o_eos.
  - The slot is "free" when o_v=0 or o_b=0 this cycle. A token may be accepted and a new one loaded on the same edge.
- Counter cnt is CNTW bits wide and holds the accumulated zeros k (1..MAXRUN-1) in S_ZEROS. A pending register holds {W bits, eos}.
- States: S_START=0, S_ZEROS=1, S_PEND=2. Encoding 3 is illegal and goes to S_START.
- i_b = (state==S_PEND) | (o_v & o_b).
- S_START, on an accepted word:
  - Nonzero: load a literal carrying i_eos; stay in S_START.
  - Zero with i_eos=1: load run n=1 (o_d=0) with o_eos=1; stay in S_START.
  - Zero with i_eos=0: cnt=1; go to S_ZEROS; no output.
- S_ZEROS, on an accepted word:
  - Zero, and k+1==MAXRUN or i_eos=1: load run n=k+1 with o_eos=i_eos; cnt=0; go to S_START.
  - Zero otherwise: cnt=k+1; no output.
  - Nonzero: load run n=k (o_eos=0); capture {i_d, i_eos} into the pending register; go to S_PEND.
- S_PEND: input is blocked. When the slot is free, load the pending literal with its eos; go to S_START.
- Without an eos, a trailing partial run is held indefinitely and never emitted spontaneously.
- Once o_v is asserted, o_d, o_z and o_eos stay stable until the token is accepted.

## Timing
- Reset values: state=S_START, cnt=0, pending=0, o_v=0, o_d=0, o_z=0, o_eos=0. With o_v=0 this gives i_b=0.
- Reset asserted mid-operation clears all state immediately. Any partial run and any pending literal are discarded.
- Latencies, measured from the accepting edge:
  - Literal from S_START, or a run-closing zero: o_v=1 after one edge.
  - Literal terminating a run: run token after one edge; literal after the run token's accept edge + 1 (earliest +2).
- Throughput is 1 word/cycle under o_b=0, except one bubble (i_b=1 for one cycle) per run terminated by a nonzero.
- Combinational paths:
  - o_b -> i_b is combinational; the producer must not feed i_b back into o_b.
  - o_v, o_d, o_z and o_eos have no combinational path from inputs.
- A word arriving while i_b=1 is not transferred and has no effect on state.

## Structure
- Package zle_pkg:
  - State enum (S_START, S_ZEROS, S_PEND).
  - Token-type constants (TOK_LIT=0, TOK_RUN=1).
  - Function maxrun(CNTW).
  - Shared by the encoder and the future decoder.
- One sub-module, zle_tok_slot: the registered output slot plus the o_v/o_b handshake and the "free" signal, parametrised by W.
- The FSM and the run counter live in zle_enc.

## Test plan
Defaults W=8, CNTW=4.
- Literals 0x05, 0x07, o_b=0 → tokens {z0,0x05} then {z0,0x07}, each one cycle after acceptance; i_b stays 0.
- 0, 0, 0, 0x09 → {z1,0x02}, then {z1... no: {z0,0x09}} one cycle later; i_b high exactly one cycle (S_PEND).
- 20 zeros, then 0x01 → {z1,0x0F}, then {z1,0x03}, then {z0,0x01}; no i_b stall during the zeros.
- Three zeros with eos on the third → {z1,0x02,eos=1}. A lone zero with eos from S_START → {z1,0x00,eos=1}. Nonzero 0x33 with eos ending a run of 2 → {z1,0x01,eos=0}, {z0,0x33,eos=1}.
- o_b held high 5 cycles with a run token valid and a literal pending → o_v and o_d stable, i_b=1, nothing lost; after release, tokens appear in order.
- reset pulsed low with cnt=7 in S_ZEROS → o_v=0 and state_o=0 immediately; the subsequent word 0x04 yields only {z0,0x04}.
